// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwarding, operand select and a valid/ready output register.
// Define ALU_OPERAND_FWD_EN to enable the EX/MEM and MEM/WB forwarding network.
//   state | meaning
//   EMPTY | no instruction held, out_valid = 0
//   FULL  | operands held for the ALU, out_valid = 1
module alu_operand_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_rs1_addr,
  input  logic [4:0]   in_rs2_addr,
  input  logic [N-1:0] in_rs1_data,
  input  logic [N-1:0] in_rs2_data,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_imm,
  input  logic         in_a_sel,
  input  logic         in_b_sel,
  input  logic [3:0]   in_alu_select,
  input  logic         exmem_wen,
  input  logic [4:0]   exmem_rd,
  input  logic [N-1:0] exmem_data,
  input  logic         memwb_wen,
  input  logic [4:0]   memwb_rd,
  input  logic [N-1:0] memwb_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   state;
  logic         capture;
  logic [N-1:0] fwd_rs1;
  logic [N-1:0] fwd_rs2;

`ifdef ALU_OPERAND_FWD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is hardwired zero.
  always_comb begin
    fwd_rs1 = in_rs1_data;
    if (exmem_wen && (exmem_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
      fwd_rs1 = exmem_data;
    else if (memwb_wen && (memwb_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
      fwd_rs1 = memwb_data;
  end

  always_comb begin
    fwd_rs2 = in_rs2_data;
    if (exmem_wen && (exmem_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
      fwd_rs2 = exmem_data;
    else if (memwb_wen && (memwb_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
      fwd_rs2 = memwb_data;
  end
`else
  // Hazard unit stalls on every RAW hazard; bypass ports are left unconnected internally.
  logic unused_fwd;
  assign unused_fwd = ^{exmem_wen, exmem_rd, exmem_data, memwb_wen, memwb_rd,
                        memwb_data, in_rs1_addr, in_rs2_addr};
  assign fwd_rs1 = in_rs1_data;
  assign fwd_rs2 = in_rs2_data;
`endif

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign capture   = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
    end else if (capture) begin
      state      <= FULL;
      alu_a      <= in_a_sel ? in_pc  : fwd_rs1;
      alu_b      <= in_b_sel ? in_imm : fwd_rs2;
      alu_select <= in_alu_select;
    end else if (flush || out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic
// against a transaction-level reference model (honours ALU_OPERAND_FWD_EN).
module tb_alu_operand_stage;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rs1_addr, in_rs2_addr;
  logic [N-1:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic         in_a_sel, in_b_sel;
  logic [3:0]   in_alu_select;
  logic         exmem_wen, memwb_wen;
  logic [4:0]   exmem_rd, memwb_rd;
  logic [N-1:0] exmem_data, memwb_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_select;

  int errors = 0;
  int checks = 0;

  // Reference model: the held transaction
  logic         m_valid;
  logic [N-1:0] m_a, m_b;
  logic [3:0]   m_sel;

  alu_operand_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_alu_select(in_alu_select),
    .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wen(memwb_wen), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_fwd(input logic [4:0] addr, input logic [N-1:0] rf);
`ifdef ALU_OPERAND_FWD_EN
    if (addr != 0 && exmem_wen && exmem_rd == addr) return exmem_data;
    if (addr != 0 && memwb_wen && memwb_rd == addr) return memwb_data;
`endif
    return rf;
  endfunction

  // Advance one clock: evaluate the model on the current inputs, then settle after the edge.
  task automatic tick();
    logic         nv;
    logic [N-1:0] na, nb;
    logic [3:0]   ns;
    nv = m_valid; na = m_a; nb = m_b; ns = m_sel;
    if (rst) begin
      nv = 0; na = 0; nb = 0; ns = 0;
    end else if (in_valid && (!m_valid || out_ready) && !flush) begin
      nv = 1;
      na = in_a_sel ? in_pc : m_fwd(in_rs1_addr, in_rs1_data);
      nb = in_b_sel ? in_imm : m_fwd(in_rs2_addr, in_rs2_data);
      ns = in_alu_select;
    end else if (flush || (m_valid && out_ready)) begin
      nv = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_a = na; m_b = nb; m_sel = ns;
  endtask

  task automatic idle_inputs();
    rst = 0; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
    in_a_sel = 0; in_b_sel = 0; in_alu_select = 0;
    exmem_wen = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wen = 0; memwb_rd = 0; memwb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'h1234; in_alu_select = 4'd7;
    m_valid = 0; m_a = 0; m_b = 0; m_sel = 0;
    for (int i = 0; i < 3; i++) begin
      in_rs2_data = $urandom;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, out_valid); end
      checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_a cyc%0d got=%h exp=0", i, alu_a); end
      checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL reset_b cyc%0d got=%h exp=0", i, alu_b); end
      checks++; if (alu_select !== 4'h0) begin errors++; $display("FAIL reset_sel cyc%0d got=%h exp=0", i, alu_select); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_basic_accept();
    idle_inputs();
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'h10; in_rs2_addr = 6; in_rs2_data = 32'h20;
    in_alu_select = 4'd12;
    tick();
    in_valid = 0; out_ready = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (alu_a !== 32'h10) begin errors++; $display("FAIL basic_a got=%h exp=10", alu_a); end
    checks++; if (alu_b !== 32'h20) begin errors++; $display("FAIL basic_b got=%h exp=20", alu_b); end
    checks++; if (alu_select !== 4'd12) begin errors++; $display("FAIL basic_sel got=%0d exp=12", alu_select); end
    out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got=%b exp=0", out_valid); end
    checks++; if (alu_a !== 32'h10) begin errors++; $display("FAIL basic_hold_a got=%h exp=10", alu_a); end
  endtask

  task automatic test_forwarding();
    logic [N-1:0] exp_a;
    idle_inputs();
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'h10; in_rs2_addr = 9; in_rs2_data = 32'h99;
    exmem_wen = 1; exmem_rd = 5; exmem_data = 32'hAA;
    memwb_wen = 1; memwb_rd = 5; memwb_data = 32'hBB;
`ifdef ALU_OPERAND_FWD_EN
    exp_a = 32'hAA;
`else
    exp_a = 32'h10;
`endif
    tick();
    checks++; if (alu_a !== exp_a) begin errors++; $display("FAIL fwd_exmem got=%h exp=%h", alu_a, exp_a); end
    checks++; if (alu_b !== 32'h99) begin errors++; $display("FAIL fwd_rs2_nohit got=%h exp=99", alu_b); end
    exmem_wen = 0;
`ifdef ALU_OPERAND_FWD_EN
    exp_a = 32'hBB;
`else
    exp_a = 32'h10;
`endif
    tick();
    checks++; if (alu_a !== exp_a) begin errors++; $display("FAIL fwd_memwb got=%h exp=%h", alu_a, exp_a); end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_guard();
    idle_inputs();
    in_valid = 1; in_rs1_addr = 0; in_rs1_data = 0; in_rs2_addr = 0; in_rs2_data = 0;
    exmem_wen = 1; exmem_rd = 0; exmem_data = 32'hFF;
    memwb_wen = 1; memwb_rd = 0; memwb_data = 32'hEE;
    tick();
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL x0_a got=%h exp=0", alu_a); end
    checks++; if (alu_b !== 32'h0) begin errors++; $display("FAIL x0_b got=%h exp=0", alu_b); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_pressure();
    idle_inputs();
    in_valid = 1; in_rs1_data = 32'h111; in_rs2_data = 32'h222; in_alu_select = 4'd4;
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_rs1_data = 32'h333 + i; in_rs2_data = 32'h444 + i; in_alu_select = 4'd6;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc%0d got=%b exp=0", i, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || alu_a !== 32'h111 || alu_b !== 32'h222 || alu_select !== 4'd4) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got v=%b a=%h b=%h s=%0d exp v=1 a=111 b=222 s=4",
                 i, out_valid, alu_a, alu_b, alu_select);
      end
    end
    out_ready = 1; in_rs1_data = 32'h555; in_rs2_data = 32'h666; in_alu_select = 4'd13;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || alu_a !== 32'h555 || alu_b !== 32'h666 || alu_select !== 4'd13) begin
      errors++;
      $display("FAIL no_bubble got v=%b a=%h b=%h s=%0d exp v=1 a=555 b=666 s=13",
               out_valid, alu_a, alu_b, alu_select);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_and_select();
    idle_inputs();
    in_valid = 1; in_rs1_data = 32'h77; in_alu_select = 4'd1;
    tick();
    out_ready = 0; flush = 1; in_rs1_data = 32'h88;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    flush = 1; out_ready = 1; in_valid = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    flush = 0; in_a_sel = 1; in_b_sel = 1; in_pc = 32'h100; in_imm = 32'hFFFF_FFFC;
    in_rs1_addr = 3; in_rs2_addr = 4; exmem_wen = 1; exmem_rd = 3; exmem_data = 32'hDEAD;
    memwb_wen = 1; memwb_rd = 4; memwb_data = 32'hBEEF; in_alu_select = 4'd15;
    tick();
    checks++; if (alu_a !== 32'h100) begin errors++; $display("FAIL sel_pc got=%h exp=100", alu_a); end
    checks++; if (alu_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sel_imm got=%h exp=fffffffc", alu_b); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_rs1_addr = 5'($urandom_range(0, 3));
      in_rs2_addr = 5'($urandom_range(0, 3));
      in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_pc = $urandom; in_imm = $urandom;
      in_a_sel = $urandom_range(0, 1) == 1; in_b_sel = $urandom_range(0, 1) == 1;
      in_alu_select = 4'($urandom_range(0, 15));
      exmem_wen = $urandom_range(0, 1) == 1; exmem_rd = 5'($urandom_range(0, 3)); exmem_data = $urandom;
      memwb_wen = $urandom_range(0, 1) == 1; memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++; $display("FAIL rand_ready cyc%0d got=%b exp=%b", i, in_ready, !m_valid || out_ready);
      end
      tick();
      checks++;
      if (out_valid !== m_valid || alu_a !== m_a || alu_b !== m_b || alu_select !== m_sel) begin
        errors++;
        $display("FAIL rand_out cyc%0d got v=%b a=%h b=%h s=%0d exp v=%b a=%h b=%h s=%0d",
                 i, out_valid, alu_a, alu_b, alu_select, m_valid, m_a, m_b, m_sel);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_accept();
    test_forwarding();
    test_x0_guard();
    test_back_pressure();
    test_flush_and_select();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
